// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target.
//   i2c_state_t : protocol state machine encoding
//   ACK / NACK  : SDA levels of the acknowledge bit
//   addr_match  : compares the address byte (7-bit address + R/W) with a device address
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Bit 0 of the address byte is R/W; only bits [7:1] carry the address.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// Pad and local-register bus bundle of the I2C register target.
//   I2C pads   : scl_pad_i/o, scl_padoen_o, sda_pad_i/o, sda_padoen_o (oen active low)
//   local bus  : loc_addr_i, loc_we_i, loc_wdata_i, loc_rdata_o (combinational read)
//   status     : i2c_wr_o / i2c_wr_addr_o (commit pulse + index), busy_o
// Modport slave is the target block, modport master is the surrounding system.
interface i2c_target_regs_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          scl_pad_i;
    logic          scl_pad_o;
    logic          scl_padoen_o;
    logic          sda_pad_i;
    logic          sda_pad_o;
    logic          sda_padoen_o;
    logic [AW-1:0] loc_addr_i;
    logic          loc_we_i;
    logic [7:0]    loc_wdata_i;
    logic [7:0]    loc_rdata_o;
    logic          i2c_wr_o;
    logic [AW-1:0] i2c_wr_addr_o;
    logic          busy_o;

    modport slave (
        input  scl_pad_i, sda_pad_i, loc_addr_i, loc_we_i, loc_wdata_i,
        output scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
        output loc_rdata_o, i2c_wr_o, i2c_wr_addr_o, busy_o
    );

    modport master (
        output scl_pad_i, sda_pad_i, loc_addr_i, loc_we_i, loc_wdata_i,
        input  scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
        input  loc_rdata_o, i2c_wr_o, i2c_wr_addr_o, busy_o
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a glitch filter for one I2C line.
//   clk_i, rst_i : block clock, asynchronous active-high reset (everything resets to 1)
//   line_i       : raw pad level
//   level_o      : filtered level
//   rise_o/fall_o: one-cycle pulses when the filtered level changes
// The filtered level only follows the synchronised input after FILTER_LEN
// consecutive samples disagree with it; any agreeing sample restarts the count.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_reg;
    logic          filt_reg;
    logic          prev_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg <= 2'b11;
            filt_reg <= 1'b1;
            prev_reg <= 1'b1;
            cnt_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], line_i};
            prev_reg <= filt_reg;
            if (sync_reg[1] == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                filt_reg <= sync_reg[1];
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level_o = filt_reg;
    assign rise_o  = filt_reg & ~prev_reg;
    assign fall_o  = ~filt_reg & prev_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing DEPTH 8-bit registers behind an auto-incrementing pointer.
//   clk_i, rst_i : block clock (>= 20x SCL), asynchronous active-high reset
//   bus (slave)  : I2C pads, local register port, commit pulse and busy flag
// Write transfer: address, pointer byte, then data bytes written at ptr++.
// Read transfer : bytes returned from ptr++ until the master NACKs.
// The pointer persists between transfers. SCL is never driven (no stretching).
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         FILTER_LEN = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    i2c_target_regs_if.slave bus
);

    localparam int   AW          = $clog2(DEPTH);
    localparam logic SDA_RELEASE = 1'b1;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .line_i  (bus.scl_pad_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .line_i  (bus.sda_pad_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_state_t    state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [AW-1:0] ptr_reg;
    logic          sda_oen_reg;
    logic          ack_on_reg;   // ACK states: first SCL fall already drove the ACK bit
    logic          rw_reg;
    logic          busy_reg;
    logic          wr_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [7:0]    mem_reg [DEPTH];

    logic          start_det;
    logic          stop_det;
    logic [7:0]    rx_byte;
    logic          commit_en;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // Byte as it stands including the bit sampled on this SCL rise.
    assign rx_byte   = {shift_reg[6:0], sda_lvl};

    assign commit_en = (state_reg == WDATA) && scl_rise && (bit_cnt_reg == 4'd7)
                       && !start_det && !stop_det;

    // Register file: an I2C commit to the same index overrides a local write.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_reg[gi] <= 8'h00;
            end else if (commit_en && (ptr_reg == AW'(gi))) begin
                mem_reg[gi] <= rx_byte;
            end else if (bus.loc_we_i && (bus.loc_addr_i == AW'(gi))) begin
                mem_reg[gi] <= bus.loc_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ptr_reg     <= '0;
            sda_oen_reg <= SDA_RELEASE;
            ack_on_reg  <= 1'b0;
            rw_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            wr_reg      <= 1'b0;
            wr_addr_reg <= '0;
        end else begin
            wr_reg <= 1'b0;
            if (stop_det) begin
                state_reg   <= IDLE;
                sda_oen_reg <= SDA_RELEASE;
                busy_reg    <= 1'b0;
            end else if (start_det) begin
                state_reg   <= ADDR;
                bit_cnt_reg <= '0;
                sda_oen_reg <= SDA_RELEASE;
                busy_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= '0;
                                ack_on_reg  <= 1'b0;
                                if (addr_match(rx_byte, DEV_ADDR)) begin
                                    rw_reg    <= rx_byte[0];
                                    state_reg <= ADDR_ACK;
                                end else begin
                                    state_reg <= IGNORE;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end

                    // First fall drives ACK, second fall (end of 9th clock) moves on.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on_reg) begin
                                sda_oen_reg <= ACK;
                                ack_on_reg  <= 1'b1;
                            end else if (rw_reg) begin
                                shift_reg   <= mem_reg[ptr_reg];
                                sda_oen_reg <= mem_reg[ptr_reg][7];
                                bit_cnt_reg <= '0;
                                state_reg   <= RDATA;
                            end else begin
                                sda_oen_reg <= SDA_RELEASE;
                                bit_cnt_reg <= '0;
                                state_reg   <= PTR;
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 4'd7) begin
                                ptr_reg     <= rx_byte[AW-1:0];
                                bit_cnt_reg <= '0;
                                ack_on_reg  <= 1'b0;
                                state_reg   <= PTR_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end

                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on_reg) begin
                                sda_oen_reg <= ACK;
                                ack_on_reg  <= 1'b1;
                            end else begin
                                sda_oen_reg <= SDA_RELEASE;
                                bit_cnt_reg <= '0;
                                state_reg   <= WDATA;
                            end
                        end
                    end

                    WDATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 4'd7) begin
                                wr_reg      <= 1'b1;
                                wr_addr_reg <= ptr_reg;
                                ptr_reg     <= ptr_reg + 1'b1;
                                bit_cnt_reg <= '0;
                                ack_on_reg  <= 1'b0;
                                state_reg   <= WDATA_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end

                    // The MSB was driven on entry; bit_cnt counts rises the master has seen.
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_oen_reg <= SDA_RELEASE;
                                ptr_reg     <= ptr_reg + 1'b1;
                                ack_on_reg  <= 1'b0;
                                state_reg   <= RDATA_ACK;
                            end else begin
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                sda_oen_reg <= shift_reg[6];
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == NACK) begin
                                state_reg <= IGNORE;
                            end else begin
                                ack_on_reg <= 1'b1;
                            end
                        end else if (scl_fall && ack_on_reg) begin
                            shift_reg   <= mem_reg[ptr_reg];
                            sda_oen_reg <= mem_reg[ptr_reg][7];
                            bit_cnt_reg <= '0;
                            state_reg   <= RDATA;
                        end
                    end

                    // IDLE and IGNORE keep SDA released until START or STOP.
                    default: begin
                        sda_oen_reg <= SDA_RELEASE;
                    end
                endcase
            end
        end
    end

    assign bus.scl_pad_o     = 1'b0;
    assign bus.scl_padoen_o  = 1'b1;
    assign bus.sda_pad_o     = 1'b0;
    assign bus.sda_padoen_o  = sda_oen_reg;
    assign bus.loc_rdata_o   = mem_reg[bus.loc_addr_i];
    assign bus.i2c_wr_o      = wr_reg;
    assign bus.i2c_wr_addr_o = wr_addr_reg;
    assign bus.busy_o        = busy_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master drives the bus,
// expected ACK bits / read bytes and commit addresses are queued by the
// stimulus and compared by a separate monitor process.
module tb_i2c_target_regs;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int Q     = 8;   // clk cycles per quarter SCL period

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    exp_t          resp_exp_q[$];
    logic [7:0]    resp_obs_q[$];
    logic [AW-1:0] wr_exp_q[$];

    i2c_target_regs_if #(.DEPTH(DEPTH)) bus ();

    i2c_target_regs #(
        .DEV_ADDR   (7'h50),
        .DEPTH      (DEPTH),
        .FILTER_LEN (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target.
    assign bus.scl_pad_i = scl_m;
    assign bus.sda_pad_i = sda_m & (bus.sda_padoen_o | bus.sda_pad_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;  tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = bus.sda_pad_i;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic expect_resp(input string name, input logic [7:0] val);
        resp_exp_q.push_back('{name, val});
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        resp_obs_q.push_back({7'b0, a});
    endtask

    task automatic read_byte(input logic master_ack);
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        resp_obs_q.push_back(d);
        write_bit(master_ack);
    endtask

    task automatic loc_read(input logic [AW-1:0] idx, input logic [7:0] exp, input string name);
        bus.loc_addr_i = idx;
        #1;
        check(name, 32'(bus.loc_rdata_o), 32'(exp));
    endtask

    task automatic loc_write(input logic [AW-1:0] idx, input logic [7:0] d);
        @(posedge clk); #2;
        bus.loc_addr_i  = idx;
        bus.loc_wdata_i = d;
        bus.loc_we_i    = 1'b1;
        @(posedge clk); #2;
        bus.loc_we_i    = 1'b0;
    endtask

    task automatic watch_busy(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.busy_o) seen = 1'b1;
        end
    endtask

    // Monitor: compares bus responses and commit pulses as they appear.
    initial begin
        logic [7:0] obs;
        exp_t       e;
        forever begin
            @(negedge clk);
            while (resp_obs_q.size() > 0) begin
                obs = resp_obs_q.pop_front();
                if (resp_exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected response: got 0x%0h, required none", obs);
                end else begin
                    e = resp_exp_q.pop_front();
                    check(e.name, 32'(obs), 32'(e.val));
                end
            end
            if (bus.i2c_wr_o) begin
                if (wr_exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected i2c_wr: got addr 0x%0h, required no pulse",
                             bus.i2c_wr_addr_o);
                end else begin
                    check("i2c_wr_addr", 32'(bus.i2c_wr_addr_o), 32'(wr_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.loc_addr_i  = '0;
        bus.loc_we_i    = 1'b0;
        bus.loc_wdata_i = 8'h00;

        // Reset state
        tick(3);
        check("reset sda_padoen", 32'(bus.sda_padoen_o), 32'd1);
        check("reset scl_padoen", 32'(bus.scl_padoen_o), 32'd1);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset i2c_wr", 32'(bus.i2c_wr_o), 32'd0);
        loc_read(4'd0, 8'h00, "reset reg0");
        rst = 1'b0;
        tick(5);

        // Write 0x11, 0x22 from pointer 3
        i2c_start();
        check("busy after start", 32'(bus.busy_o), 32'd1);
        expect_resp("ack addr A0", 8'h00); write_byte(8'hA0);
        expect_resp("ack ptr 03", 8'h00);  write_byte(8'h03);
        wr_exp_q.push_back(4'd3);
        expect_resp("ack data 11", 8'h00); write_byte(8'h11);
        wr_exp_q.push_back(4'd4);
        expect_resp("ack data 22", 8'h00); write_byte(8'h22);
        i2c_stop();
        tick(Q);
        check("busy after stop", 32'(bus.busy_o), 32'd0);
        loc_read(4'd3, 8'h11, "reg3 after write");
        loc_read(4'd4, 8'h22, "reg4 after write");

        // Pointer wrap 15 -> 0
        i2c_start();
        expect_resp("ack addr A0 wrap", 8'h00); write_byte(8'hA0);
        expect_resp("ack ptr 0F", 8'h00);       write_byte(8'h0F);
        wr_exp_q.push_back(4'd15);
        expect_resp("ack data AA", 8'h00);      write_byte(8'hAA);
        wr_exp_q.push_back(4'd0);
        expect_resp("ack data BB", 8'h00);      write_byte(8'hBB);
        i2c_stop();
        tick(Q);
        loc_read(4'd15, 8'hAA, "reg15 wrap");
        loc_read(4'd0, 8'hBB, "reg0 wrap");

        // Pointer set, repeated START, read two bytes
        i2c_start();
        expect_resp("ack addr A0 rd", 8'h00); write_byte(8'hA0);
        expect_resp("ack ptr 03 rd", 8'h00);  write_byte(8'h03);
        i2c_start();
        expect_resp("ack addr A1", 8'h00);    write_byte(8'hA1);
        expect_resp("read byte 0", 8'h11);    read_byte(1'b0);
        expect_resp("read byte 1", 8'h22);    read_byte(1'b1);
        check("sda released after nack", 32'(bus.sda_padoen_o), 32'd1);
        i2c_stop();
        tick(Q);

        // Address mismatch
        i2c_start();
        expect_resp("nack addr B0", 8'h01);     write_byte(8'hB0);
        check("busy during ignore", 32'(bus.busy_o), 32'd1);
        expect_resp("nack ignored byte", 8'h01); write_byte(8'h55);
        check("busy still during ignore", 32'(bus.busy_o), 32'd1);
        i2c_stop();
        tick(Q);
        check("busy after ignore stop", 32'(bus.busy_o), 32'd0);
        loc_read(4'd3, 8'h11, "reg3 untouched by mismatch");

        // Pointer persists; local write after shift load does not alter the read byte
        i2c_start();
        expect_resp("ack addr A0 ptr", 8'h00); write_byte(8'hA0);
        expect_resp("ack ptr 0F only", 8'h00); write_byte(8'h0F);
        i2c_stop();
        i2c_start();
        expect_resp("ack addr A1 ptr", 8'h00); write_byte(8'hA1);
        loc_write(4'd15, 8'h33);
        expect_resp("read persisted ptr", 8'hAA); read_byte(1'b1);
        i2c_stop();
        tick(Q);
        loc_read(4'd15, 8'h33, "reg15 local write");

        // Glitch filter on SDA while SCL high
        sda_m = 1'b0; tick(1); sda_m = 1'b1;
        watch_busy(20, seen);
        check("1-cycle glitch ignored", 32'(seen), 32'd0);
        sda_m = 1'b0; tick(4); sda_m = 1'b1;
        watch_busy(20, seen);
        check("4-cycle pulse detected", 32'(seen), 32'd1);
        check("busy after pulse stop", 32'(bus.busy_o), 32'd0);

        // Reset during bit 4 of a read of reg4 (0x22, bit 4 is 0)
        i2c_start();
        expect_resp("ack addr A0 rst", 8'h00); write_byte(8'hA0);
        expect_resp("ack ptr 04 rst", 8'h00);  write_byte(8'h04);
        i2c_start();
        expect_resp("ack addr A1 rst", 8'h00); write_byte(8'hA1);
        for (int i = 0; i < 3; i++) begin
            logic b;
            read_bit(b);
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check("bit4 driven low", 32'(bus.sda_padoen_o), 32'd0);
        rst = 1'b1;
        #1;
        check("async release on reset", 32'(bus.sda_padoen_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            loc_read(AW'(i), 8'h00, $sformatf("reset reg%0d", i));
        end
        tick(2);
        rst = 1'b0;
        tick(Q);
        check("busy after mid-read reset", 32'(bus.busy_o), 32'd0);

        // Bus activity without a fresh START is ignored
        scl_m = 1'b0; tick(Q);
        expect_resp("no ack without start", 8'h01); write_byte(8'hA0);
        check("sda released without start", 32'(bus.sda_padoen_o), 32'd1);
        i2c_stop();
        i2c_start();
        expect_resp("ack addr A1 fresh", 8'h00); write_byte(8'hA1);
        expect_resp("read reg0 after reset", 8'h00); read_byte(1'b1);
        i2c_stop();

        tick(20);
        check("leftover expectations", 32'(resp_exp_q.size() + wr_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit I2C target address it responds to.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of 8-bit registers; it is a power of two in the range 2..256.
REQ-003 SHALL have parameter FILTER_LEN, default 3, meaning how many consecutive equal synchronised samples are needed before a filtered SCL/SDA level changes.
REQ-004 clk_i  in  1  block clock; must run at least 20x the SCL frequency.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 scl_pad_i  in  1  SCL line input.
REQ-007 scl_pad_o  out  1  constant 0; this block does not stretch the clock.
REQ-008 scl_padoen_o  out  1  constant 1, meaning SCL is never driven.
REQ-009 sda_pad_i  in  1  SDA line input.
REQ-010 sda_pad_o  out  1  constant 0, for open-drain use.
REQ-011 sda_padoen_o  out  1  SDA output enable, active low; 0 pulls SDA low.
REQ-012 loc_addr_i  in  $clog2(DEPTH)  local register index.
REQ-013 loc_we_i  in  1  local write strobe.
REQ-014 loc_wdata_i  in  8  local write data.
REQ-015 loc_rdata_o  out  8  combinational read of reg[loc_addr_i].
REQ-016 i2c_wr_o  out  1  one-cycle pulse when an I2C data byte is committed.
REQ-017 i2c_wr_addr_o  out  $clog2(DEPTH)  index of the committed byte.
REQ-018 busy_o  out  1  high from a detected START until the next detected STOP.

Function
REQ-019 SCL and SDA SHALL each pass through 2 synchronising flops, then the FILTER_LEN glitch filter; all protocol logic SHALL use only the filtered levels and their edges.
REQ-020 START (filtered SDA falling while filtered SCL high) SHALL force state ADDR and clear the bit counter from any state, including a repeated START.
REQ-021 STOP (filtered SDA rising while filtered SCL high) SHALL force state IDLE and release SDA from any state.
REQ-022 The state machine SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-023 Bits SHALL be MSB first; input bits are sampled on filtered SCL rising; SDA enable changes only on filtered SCL falling.
REQ-024 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR the block SHALL drive ACK in ADDR_ACK; otherwise it goes to IGNORE with SDA released.
REQ-025 After ADDR_ACK, a write (R/W=0) SHALL go to PTR; a read SHALL load shift = reg[ptr] and go to RDATA.
REQ-026 PTR: the received byte SHALL set ptr = byte mod DEPTH, followed by an ACK.
REQ-027 WDATA: each received byte SHALL be written to reg[ptr] and ACKed; i2c_wr_o SHALL pulse with the old ptr; ptr then increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-028 RDATA: the block SHALL drive shift bits for 8 SCL cycles, then release SDA and ptr++.
REQ-029 RDATA_ACK: the master's ACK SHALL reload shift = reg[ptr] and return to RDATA; a NACK SHALL go to IGNORE.
REQ-030 ptr SHALL persist across transactions, so a read after a pointer-only write starts at that pointer.
REQ-031 If a local write and an I2C commit hit the same index in the same cycle, the I2C value SHALL win; for different indices both SHALL take effect.
REQ-032 A local write SHALL NOT disturb a read byte already loaded into shift.
REQ-033 IGNORE SHALL keep SDA released until the next START or STOP.

Reset
REQ-034 While rst_i is high, the block SHALL immediately force: state IDLE, sda_padoen_o=1, ptr=0, all registers 8'h00, i2c_wr_o=0, busy_o=0, synchronisers and filters = 1.
REQ-035 Reset asserted mid-byte SHALL release SDA asynchronously; after reset deasserts, the block SHALL ignore the bus until a fresh START.

Structure
REQ-036 The state enum and ACK/NACK constants SHALL live in shared package i2c_pkg.
REQ-037 The synchroniser plus glitch filter SHALL be sub-module i2c_line_filter, instantiated once for SCL and once for SDA.

Verification
REQ-038 Write: START, 0xA0, ptr 0x03, data 0x11, 0x22, STOP -> all ACKed; reg[3]=0x11, reg[4]=0x22; two i2c_wr_o pulses with addresses 3 and 4.
REQ-039 Wrap: ptr 0x0F, data 0xAA, 0xBB -> reg[15]=0xAA, reg[0]=0xBB.
REQ-040 Read with repeated START: write ptr 0x03, repeated START, 0xA1, read 2 bytes (ACK then NACK) -> 0x11, 0x22 returned; SDA released after the NACK.
REQ-041 Address mismatch: START, 0xB0 -> no ACK (SDA high at the 9th clock); registers unchanged; busy_o stays high until STOP.
REQ-042 Glitch: 1-cycle SDA pulse while SCL high -> no START/STOP detected; a FILTER_LEN+1 cycle pulse is detected.
REQ-043 Reset during bit 4 of a read byte -> sda_padoen_o=1 in the same cycle; loc_rdata_o=0x00 for every index.
